ysyx_22041071_axi_rd_arb: RTL and testbench

Two-requester arbiter in front of the single CPU-side port of the AXI read master. The instruction-fetch (IF) and load/store (LSU) paths compete for that port. The arbiter grants one requester at a time with round-robin priority, latches that requester's request, and issues it downstream. It then routes the returned beats back to the owner, counting beats to produce a per-requester last flag.

---
 rtl/ysyx_22041071_axi_rd_arb.sv | 160 ++++++++++++++++
 tb/tb_ysyx_22041071_axi_rd_arb.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041071_axi_rd_arb.sv
// Round-robin arbiter sharing the AXI read master's CPU-side port between the
// instruction-fetch and load/store paths, routing returned beats back to the owner.
module ysyx_22041071_axi_rd_arb #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  input  logic [LEN_W-1:0]  if_req_len,
  input  logic [1:0]        if_req_size,
  output logic              if_req_ready,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_resp_data,
  output logic [1:0]        if_resp_resp,
  output logic              if_resp_last,

  input  logic              lsu_req_valid,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic [LEN_W-1:0]  lsu_req_len,
  input  logic [1:0]        lsu_req_size,
  output logic              lsu_req_ready,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_resp_data,
  output logic [1:0]        lsu_resp_resp,
  output logic              lsu_resp_last,

  output logic              rd_valid,
  output logic [ID_W-1:0]   rd_id,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [LEN_W-1:0]  rd_len,
  output logic [1:0]        rd_size,
  input  logic              rd_ready,
  input  logic              rd_r_valid,
  input  logic [DATA_W-1:0] rd_r_data,
  input  logic [1:0]        rd_r_resp,

  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DATA  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               owner_q;       // 0 = IF, 1 = LSU
  logic               last_grant_q;  // requester granted most recently
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   len_q;
  logic [1:0]         size_q;
  logic [LEN_W-1:0]   beat_cnt_q;

  logic               grant_if;
  logic               grant_lsu;
  logic               last_beat;

  // On a tie the requester that did not win last time is favoured; the two
  // grants are mutually exclusive by construction.
  assign grant_if  = if_req_valid  & (~lsu_req_valid | last_grant_q);
  assign grant_lsu = lsu_req_valid & (~if_req_valid  | ~last_grant_q);
  assign last_beat = (beat_cnt_q == len_q);

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves a value held and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    if_req_ready   = 1'b0;
    lsu_req_ready  = 1'b0;
    if_resp_valid  = 1'b0;
    if_resp_data   = '0;
    if_resp_resp   = 2'b00;
    if_resp_last   = 1'b0;
    lsu_resp_valid = 1'b0;
    lsu_resp_data  = '0;
    lsu_resp_resp  = 2'b00;
    lsu_resp_last  = 1'b0;
    rd_valid       = 1'b0;
    rd_id          = '0;
    rd_addr        = '0;
    rd_len         = '0;
    rd_size        = 2'b00;
    busy           = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if_req_ready  = grant_if;
        lsu_req_ready = grant_lsu;
        if (grant_if || grant_lsu) state_d = S_ISSUE;
      end

      S_ISSUE: begin
        rd_valid = 1'b1;
        rd_id    = ID_W'(owner_q);
        rd_addr  = addr_q;
        rd_len   = len_q;
        rd_size  = size_q;
        if (rd_ready) state_d = S_DATA;
      end

      S_DATA: begin
        // Beats are forwarded with zero latency; requesters cannot stall them.
        if (owner_q) begin
          lsu_resp_valid = rd_r_valid;
          lsu_resp_data  = rd_r_valid ? rd_r_data : '0;
          lsu_resp_resp  = rd_r_valid ? rd_r_resp : 2'b00;
          lsu_resp_last  = rd_r_valid & last_beat;
        end else begin
          if_resp_valid  = rd_r_valid;
          if_resp_data   = rd_r_valid ? rd_r_data : '0;
          if_resp_resp   = rd_r_valid ? rd_r_resp : 2'b00;
          if_resp_last   = rd_r_valid & last_beat;
        end
        if (rd_r_valid && last_beat) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= 2'b00;
      beat_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (grant_if || grant_lsu) begin
            owner_q      <= grant_lsu;
            last_grant_q <= grant_lsu;
            addr_q       <= grant_lsu ? lsu_req_addr : if_req_addr;
            len_q        <= grant_lsu ? lsu_req_len  : if_req_len;
            size_q       <= grant_lsu ? lsu_req_size : if_req_size;
          end
        end
        S_ISSUE: begin
          if (rd_ready) beat_cnt_q <= '0;
        end
        S_DATA: begin
          if (rd_r_valid) beat_cnt_q <= beat_cnt_q + LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041071_axi_rd_arb.sv
// Scoreboard bench for the IF/LSU read arbiter: stimulus pushes expected
// downstream requests and response beats, monitors compare on the falling edge.
module tb_ysyx_22041071_axi_rd_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req_valid, lsu_req_valid;
  logic [63:0] if_req_addr, lsu_req_addr;
  logic [7:0]  if_req_len, lsu_req_len;
  logic [1:0]  if_req_size, lsu_req_size;
  logic        if_req_ready, lsu_req_ready;
  logic        if_resp_valid, lsu_resp_valid;
  logic [63:0] if_resp_data, lsu_resp_data;
  logic [1:0]  if_resp_resp, lsu_resp_resp;
  logic        if_resp_last, lsu_resp_last;
  logic        rd_valid, rd_ready, rd_r_valid;
  logic [3:0]  rd_id;
  logic [63:0] rd_addr, rd_r_data;
  logic [7:0]  rd_len;
  logic [1:0]  rd_size, rd_r_resp;
  logic        busy;

  always #5 clk = ~clk;

  ysyx_22041071_axi_rd_arb dut (
    .clk(clk), .reset_n(reset_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_len(if_req_len),
    .if_req_size(if_req_size), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .if_resp_resp(if_resp_resp), .if_resp_last(if_resp_last),
    .lsu_req_valid(lsu_req_valid), .lsu_req_addr(lsu_req_addr), .lsu_req_len(lsu_req_len),
    .lsu_req_size(lsu_req_size), .lsu_req_ready(lsu_req_ready),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
    .lsu_resp_resp(lsu_resp_resp), .lsu_resp_last(lsu_resp_last),
    .rd_valid(rd_valid), .rd_id(rd_id), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_size(rd_size), .rd_ready(rd_ready),
    .rd_r_valid(rd_r_valid), .rd_r_data(rd_r_data), .rd_r_resp(rd_r_resp),
    .busy(busy)
  );

  typedef struct packed {
    logic        owner;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [1:0]  size;
  } req_t;

  beat_t beat_q[$];
  req_t  req_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor: every presented beat must match the head of the queue.
  always @(negedge clk) begin
    beat_t got, exp;
    if (if_resp_valid || lsu_resp_valid) begin
      check("resp_exclusive", {if_resp_valid, lsu_resp_valid} == 2'b11, 1'b0);
      if (beat_q.size() == 0) begin
        check("unexpected_beat", {if_resp_valid, lsu_resp_valid}, 2'b00);
      end else begin
        exp       = beat_q.pop_front();
        got.owner = lsu_resp_valid;
        got.data  = lsu_resp_valid ? lsu_resp_data : if_resp_data;
        got.resp  = lsu_resp_valid ? lsu_resp_resp : if_resp_resp;
        got.last  = lsu_resp_valid ? lsu_resp_last : if_resp_last;
        check("resp_beat", got, exp);
      end
    end
  end

  // Downstream request monitor: checked at the handshake.
  always @(negedge clk) begin
    req_t got, exp;
    if (rd_valid && rd_ready) begin
      if (req_q.size() == 0) begin
        check("unexpected_rd_req", rd_valid, 1'b0);
      end else begin
        exp = req_q.pop_front();
        got = '{id: rd_id, addr: rd_addr, len: rd_len, size: rd_size};
        check("rd_request", got, exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_if(input logic v, input logic [63:0] a, input logic [7:0] l, input logic [1:0] s);
    if_req_valid = v; if_req_addr = a; if_req_len = l; if_req_size = s;
  endtask

  task automatic set_lsu(input logic v, input logic [63:0] a, input logic [7:0] l, input logic [1:0] s);
    lsu_req_valid = v; lsu_req_addr = a; lsu_req_len = l; lsu_req_size = s;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    set_if(0, '0, '0, '0);
    set_lsu(0, '0, '0, '0);
    rd_ready = 0; rd_r_valid = 0; rd_r_data = '0; rd_r_resp = '0;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_rd", {rd_valid, rd_id, rd_addr, rd_len, rd_size}, '0);
    check("rst_resp", {if_resp_valid, if_resp_last, lsu_resp_valid, lsu_resp_last}, 4'b0);
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Called in an IDLE cycle with the valids already driven; the expected
  // winner is given by the caller and its request becomes the expected issue.
  task automatic expect_grant(input logic lsu, input string name);
    @(negedge clk);
    check(name, {if_req_ready, lsu_req_ready}, lsu ? 2'b01 : 2'b10);
    if (lsu) req_q.push_back('{id: 4'd1, addr: lsu_req_addr, len: lsu_req_len, size: lsu_req_size});
    else     req_q.push_back('{id: 4'd0, addr: if_req_addr, len: if_req_len, size: if_req_size});
    @(posedge clk);
    #1;
    if (lsu) lsu_req_valid = 1'b0;
    else     if_req_valid  = 1'b0;
  endtask

  task automatic issue(input int stall, input logic [63:0] exp_addr);
    rd_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_rd_valid", rd_valid, 1'b1);
      check("stall_rd_addr", rd_addr, exp_addr);
      check("stall_no_ready", {if_req_ready, lsu_req_ready}, 2'b00);
      tick();
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic beat(input logic owner, input logic [63:0] d, input logic [1:0] r,
                      input logic last, input int gap);
    rd_r_valid = 1'b1; rd_r_data = d; rd_r_resp = r;
    beat_q.push_back('{owner: owner, data: d, resp: r, last: last});
    @(negedge clk);
    check("data_no_ready", {if_req_ready, lsu_req_ready}, 2'b00);
    tick();
    rd_r_valid = 1'b0; rd_r_data = '0; rd_r_resp = '0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      check("gap_busy", busy, 1'b1);
      tick();
    end
  endtask

  initial begin
    do_reset();

    // Single IF beat.
    set_if(1, 64'h8000_0000, 8'd0, 2'b11);
    @(negedge clk);
    check("t1_if_ready", {if_req_ready, lsu_req_ready}, 2'b10);
    req_q.push_back('{id: 4'd0, addr: 64'h8000_0000, len: 8'd0, size: 2'b11});
    tick();
    if_req_valid = 1'b0;
    issue(0, 64'h8000_0000);
    beat(0, 64'h1122_3344_5566_7788, 2'b00, 1, 0);
    @(negedge clk);
    check("t1_idle", busy, 1'b0);
    // A stray beat while idle must not be forwarded.
    tick();
    rd_r_valid = 1'b1; rd_r_data = 64'hdead_beef;
    @(negedge clk);
    check("idle_beat_ignored", {if_resp_valid, lsu_resp_valid}, 2'b00);
    tick();
    rd_r_valid = 1'b0;

    // Round-robin ties: IF, LSU, IF.
    do_reset();
    set_if(1, 64'h1000, 8'd1, 2'b11);
    set_lsu(1, 64'h2000, 8'd0, 2'b10);
    expect_grant(0, "tie1_if");
    issue(0, 64'h1000);
    beat(0, 64'hA0, 2'b00, 0, 0);
    set_if(1, 64'h3000, 8'd0, 2'b01);
    beat(0, 64'hA1, 2'b00, 1, 0);
    expect_grant(1, "tie2_lsu");
    issue(0, 64'h2000);
    beat(1, 64'hB0, 2'b00, 1, 0);
    set_lsu(1, 64'h4000, 8'd0, 2'b00);
    expect_grant(0, "tie3_if");
    issue(0, 64'h3000);
    beat(0, 64'hC0, 2'b00, 1, 0);
    // LSU is still requesting and now wins alone.
    expect_grant(1, "lsu_after_tie");
    issue(0, 64'h4000);
    beat(1, 64'hC1, 2'b00, 1, 0);

    // LSU len=3 with two-cycle gaps between beats.
    set_lsu(1, 64'h5000, 8'd3, 2'b11);
    expect_grant(1, "t3_lsu");
    issue(0, 64'h5000);
    for (int i = 0; i < 4; i++) beat(1, 64'hD0 + 64'(i), 2'b00, i == 3, (i == 3) ? 0 : 2);
    @(negedge clk);
    check("t3_idle", busy, 1'b0);

    // Downstream stalls the request for five cycles.
    tick();
    set_if(1, 64'h6000, 8'd0, 2'b11);
    set_lsu(1, 64'h7000, 8'd0, 2'b11);
    expect_grant(0, "t4_if");
    lsu_req_valid = 1'b0;
    issue(5, 64'h6000);
    beat(0, 64'hE0, 2'b00, 1, 0);

    // Error response on the first beat of a two-beat burst.
    set_lsu(1, 64'h8000, 8'd1, 2'b11);
    expect_grant(1, "t5_lsu");
    issue(0, 64'h8000);
    beat(1, 64'hF0, 2'b10, 0, 0);
    @(negedge clk);
    check("t5_busy_mid", busy, 1'b1);
    tick();
    beat(1, 64'hF1, 2'b00, 1, 0);
    @(negedge clk);
    check("t5_idle", busy, 1'b0);

    // Maximum length burst: 256 beats, last only on the final one.
    tick();
    set_lsu(1, 64'h9000, 8'd255, 2'b11);
    expect_grant(1, "t_len255");
    issue(0, 64'h9000);
    for (int i = 0; i < 256; i++) beat(1, 64'(i) * 3, 2'b00, i == 255, 0);
    @(negedge clk);
    check("len255_idle", busy, 1'b0);

    // Reset during beat 2 of an eight-beat IF burst.
    do_reset();
    set_if(1, 64'hA000, 8'd7, 2'b11);
    expect_grant(0, "t6_if");
    issue(0, 64'hA000);
    beat(0, 64'h100, 2'b00, 0, 0);
    rd_r_valid = 1'b1; rd_r_data = 64'h101;
    #1 reset_n = 1'b0;
    @(negedge clk);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_resp", {if_resp_valid, if_resp_last, if_resp_data}, '0);
    check("t6_rst_rd", {rd_valid, rd_addr}, '0);
    tick();
    rd_r_valid = 1'b0; rd_r_data = '0;
    reset_n = 1'b1;
    tick();
    set_if(1, 64'hB000, 8'd0, 2'b10);
    expect_grant(0, "t6_after_rst");
    issue(0, 64'hB000);
    beat(0, 64'h200, 2'b00, 1, 0);
    @(negedge clk);
    check("t6_idle", busy, 1'b0);

    repeat (2) @(negedge clk);
    check("beat_q_drained", beat_q.size(), 0);
    check("req_q_drained", req_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
